// File: rtl/nyakuo_pkg.sv
// Shared types and constants for the core memory-port arbiter.
// No logic; consumed by mem_port_arbiter and arb_pick.
// Backpressure: n/a.
package nyakuo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

  localparam int   REQ_IFETCH   = 0;
  localparam int   REQ_LSU      = 1;
  localparam logic MEM_RW_READ  = 1'b0;
  localparam logic MEM_RW_WRITE = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// One-hot winner select: first valid bit found searching upward from start, wrapping.
// Latency: purely combinational.
// Backpressure: none; any = 0 when no bit of valid is set.
module arb_pick
  import nyakuo_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] kk;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    kk    = '0;
    for (int i = 0; i < N; i++) begin
      kk = IW'((int'(start) + i) % N);
      if (!any && valid[kk]) begin
        any       = 1'b1;
        idx       = kk;
        grant[kk] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between NUM_REQ requesters; MEM_ARB_ROUND_ROBIN_EN selects round-robin.
// Latency: write accepted/committed in the grant cycle, read response one cycle after grant.
// Backpressure: ready is one-hot to the winner in IDLE only; losers hold their request.
module mem_port_arbiter
  import nyakuo_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      mem_rw_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_data_o,
  input  logic [DATA_W-1:0]         mem_out_i
);

  localparam int IW = idx_w(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       owner_q;
  logic [IW-1:0]       start;
  logic [IW-1:0]       win_idx;
  logic [NUM_REQ-1:0]  win_gnt;
  logic                win_any;
  logic                grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr_q;

  assign start = (rr_ptr_q == IW'(NUM_REQ - 1)) ? '0 : rr_ptr_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= IW'(NUM_REQ - 1);
    end else if (grant) begin
      rr_ptr_q <= win_idx;
    end
  end
`else
  assign start = '0;
`endif

  arb_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .valid (req_valid_i),
    .start (start),
    .grant (win_gnt),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign grant       = (state_q == IDLE) && win_any;
  assign rsp_rdata_o = mem_out_i;

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    mem_rw_o    = MEM_RW_READ;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          req_ready_o = win_gnt;
          mem_rw_o    = req_we_i[win_idx];
          mem_addr_o  = req_addr_i[win_idx*ADDR_W +: ADDR_W];
          mem_data_o  = req_wdata_i[win_idx*DATA_W +: DATA_W];
          if (req_we_i[win_idx] == MEM_RW_READ) state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant && (req_we_i[win_idx] == MEM_RW_READ)) owner_q <= win_idx;
    end
  end

  // A requester must hold its whole request stable until it is accepted.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
    a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[g] && !req_ready_o[g]) |=>
        (req_valid_i[g] && $stable(req_we_i[g]) &&
         $stable(req_addr_i[g*ADDR_W +: ADDR_W]) &&
         $stable(req_wdata_i[g*DATA_W +: DATA_W])));
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port `memory` instance between NUM_REQ requesters, e.g. instruction fetch (index 0) and load/store (index 1). Each requester uses a valid/ready request channel and a one-cycle response pulse. The block sequences each access onto the memory's `rw_i`/`addr_i`/`data_i`/`out_o` port and routes read data back to the owner. It sits in `core` between the pipeline stages and the memory instance.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous reset, active low
- req_valid_i  in  NUM_REQ  request pending, one bit per requester
- req_we_i  in  NUM_REQ  1 = write, 0 = read
- req_addr_i  in  NUM_REQ×ADDR_W  packed request addresses
- req_wdata_i  in  NUM_REQ×DATA_W  packed write data
- req_ready_o  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- rsp_valid_o  out  NUM_REQ  read data valid, one-cycle pulse (one-hot or zero)
- rsp_rdata_o  out  DATA_W  read data, shared by all requesters
- mem_rw_o  out  1  to memory `rw_i`, 1 = write
- mem_addr_o  out  ADDR_W  to memory `addr_i`
- mem_data_o  out  DATA_W  to memory `data_i`
- mem_out_i  in  DATA_W  from memory `out_o`; valid the cycle after the address is presented

## Operation
- FSM states:
  - IDLE:
    - If any `req_valid_i` bit is set, pick a winner g.
    - Drive `mem_*_o` combinationally from requester g's fields.
    - Assert `req_ready_o[g]`.
    - If write: stay in IDLE.
    - If read: latch owner ← g and go to RESP.
  - RESP:
    - Assert `rsp_valid_o[owner]`.
    - `rsp_rdata_o` = `mem_out_i`.
    - `req_ready_o` = 0, `mem_rw_o` = 0.
    - Next state IDLE unconditionally.
- No grant: `mem_rw_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0. A read is never side-effecting.
- A requester holds valid, we, addr and wdata stable until it sees ready. Dropping valid before ready is illegal; this is checked by assertion.
- Arbitration: fixed priority (lowest index wins) unless the round-robin macro is defined (see Configuration).
- `rsp_rdata_o` equals `mem_out_i` in every cycle. Only `rsp_valid_o` qualifies it.
- Asserting `rst_ni` mid-read forces IDLE. The pending response is discarded and no `rsp_valid_o` pulse follows.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready_o` = 0, `rsp_valid_o` = 0
  - `mem_rw_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0
  - rr pointer = NUM_REQ-1, owner = 0
- Write: accepted and committed in the same cycle (cycle N). The memory samples on edge N→N+1. Back-to-back writes sustain 1 per cycle.
- Read: accepted in cycle N, `rsp_valid_o` in cycle N+1. At best 1 read per 2 cycles, because no grant is issued in RESP.
- A request that arrives during RESP is first eligible in the following IDLE cycle.
- When all requesters are valid at once, exactly one ready is asserted. The others wait with no loss of request.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - Defined:
    - Round-robin arbitration.
    - The search starts at pointer+1, modulo NUM_REQ.
    - The pointer updates to g on every grant, both read and write.
    - Reset pointer NUM_REQ-1, so requester 0 wins first.
    - Any continuously valid requester is granted within NUM_REQ grants.
  - Undefined:
    - Fixed priority, lowest index wins.
    - No pointer register.
    - A high-priority requester may starve the others.

## Structure
- `nyakuo_pkg` holds:
  - `arb_state_e` enum (IDLE, RESP)
  - `REQ_IFETCH` = 0, `REQ_LSU` = 1 index constants
  - `MEM_RW_READ` = 1'b0, `MEM_RW_WRITE` = 1'b1
- One sub-module, `arb_pick`:
  - Combinational one-hot winner select from a valid vector and a start index.
  - Fixed mode passes start = 0.
- Top-level holds the FSM, owner register, rr pointer, and mux/demux.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0, and no grant while `req_valid_i` = 0.
- Req0 read addr 0x8000_0000, memory holds 0x0000_0013 → ready[0] in cycle N, `rsp_valid_o` = 2'b01 with data 0x0000_0013 in N+1, no grant in N+1.
- Req1 writes 0xDEAD_BEEF to 0x10 on 3 consecutive cycles, then reads 0x10 → three readies in a row with `mem_rw_o` = 1, then response 0xDEAD_BEEF.
- Both requesters valid for 8 cycles, both doing reads:
  - Fixed mode: req0 granted every IDLE, req1 never.
  - `MEM_ARB_ROUND_ROBIN_EN`: grants alternate 0, 1, 0, 1.
- `rst_ni` pulled low in the RESP cycle of a req1 read → no `rsp_valid_o`; after release, state IDLE and a new req0 read completes normally.
- Req0 write and req1 read valid simultaneously in round-robin mode with pointer = 0 → req1 granted, req0 granted in the first IDLE after the response.
